memtrol: RTL

MEMTROL -- requirements
Module: memtrol

---
 rtl/memtrol.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/memtrol.sv
// Memory-stage controller: drives a single-outstanding request/response bus for
// loads and stores, aligns store data, extracts load data, and forwards ALU results.
module memtrol #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_waddr,
    input  logic [31:0] rd_wdata,
    input  logic [3:0]  byte_sel,
    input  logic        un_sign,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_wdata_o,
    output logic        hold_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    function automatic logic f_misaligned(input logic [3:0] sel, input logic [1:0] ofs);
        case (sel)
            4'b0011: f_misaligned = ofs[0];
            4'b1111: f_misaligned = (ofs != 2'd0);
            default: f_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] f_load_extract(input logic [31:0] rdata, input logic [3:0] sel,
                                                   input logic [1:0] ofs, input logic sext);
        logic [31:0] sh;
        sh = rdata >> {ofs, 3'b000};
        case (sel)
            4'b0001: f_load_extract = {{24{sext & sh[7]}}, sh[7:0]};
            4'b0011: f_load_extract = {{16{sext & sh[15]}}, sh[15:0]};
            default: f_load_extract = sh;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_abort;
    logic        w_mem_req;
    logic [31:0] w_addr;
    logic        w_misalign;
    logic        w_load_done;

    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wstrb;

    logic        r_store;
    logic [1:0]  r_ofs;
    logic [3:0]  r_sel;
    logic        r_sext;
    logic [4:0]  r_rd;

    logic        r_rd_we;
    logic [4:0]  r_rd_waddr;
    logic [31:0] r_rd_wdata;
    logic        r_misalign;
    logic        r_bus_err;

    // A store takes priority when both requests are raised together.
    assign w_mem_req   = mem_re | mem_we;
    assign w_addr      = mem_we ? mem_waddr : mem_raddr;
    assign w_misalign  = f_misaligned(byte_sel, w_addr[1:0]);
    assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_timeout   = (w_cnt_inc >= TIMEOUT);
    assign w_load_done = (r_state == S_WAIT) && bus_rvalid && !r_store;

    assign hold_o     = (r_state != S_IDLE) || (w_mem_req && !w_misalign);
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_wstrb  = r_bus_wstrb;
    assign rd_we_o    = r_rd_we;
    assign rd_waddr_o = r_rd_waddr;
    assign rd_wdata_o = r_rd_wdata;
    assign misalign_o = r_misalign;
    assign bus_err_o  = r_bus_err;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a response seen in REQ is ignored, and rvalid beats the watchdog in WAIT.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_req && !w_misalign) begin
                    w_state_next = S_REQ;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else if (bus_gnt) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Watchdog: held at zero while idle, counts saturating while a transaction is open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Bus request registers: loaded on acceptance, held through REQ, zero otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_wstrb <= 4'd0;
        end else if (w_state_next == S_REQ) begin
            r_bus_req <= 1'b1;
            if (r_state == S_IDLE) begin
                r_bus_we    <= mem_we;
                r_bus_addr  <= {w_addr[31:2], 2'b00};
                r_bus_wdata <= mem_we ? (mem_wdata << {w_addr[1:0], 3'b000}) : 32'd0;
                r_bus_wstrb <= mem_we ? (byte_sel << w_addr[1:0]) : 4'd0;
            end
        end else begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_wstrb <= 4'd0;
        end
    end

    // Transaction context needed later to shape and route the load response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_store <= 1'b0;
            r_ofs   <= 2'd0;
            r_sel   <= 4'd0;
            r_sext  <= 1'b0;
            r_rd    <= 5'd0;
        end else if ((r_state == S_IDLE) && (w_state_next == S_REQ)) begin
            r_store <= mem_we;
            r_ofs   <= w_addr[1:0];
            r_sel   <= byte_sel;
            r_sext  <= un_sign;
            r_rd    <= rd_waddr;
        end
    end

    // Register write-back: forwarded ALU results when idle, extracted data after a load response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_we    <= 1'b0;
            r_rd_waddr <= 5'd0;
            r_rd_wdata <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (w_mem_req) begin
                r_rd_we <= 1'b0;
            end else begin
                r_rd_we    <= (rd_waddr != 5'd0);
                r_rd_waddr <= rd_waddr;
                r_rd_wdata <= rd_wdata;
            end
        end else if (w_load_done) begin
            r_rd_we    <= (r_rd != 5'd0);
            r_rd_waddr <= r_rd;
            r_rd_wdata <= f_load_extract(bus_rdata, r_sel, r_ofs, r_sext);
        end else begin
            r_rd_we <= 1'b0;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_misalign <= (r_state == S_IDLE) && w_mem_req && w_misalign;
            r_bus_err  <= w_abort;
        end
    end

endmodule
